dac_sample_pacer: RTL
=====================

Name: dac_sample_pacer

Overview:
- Sits between the sound core's sample output and the SPI DAC serializer.
- Accepts samples from the core at an arbitrary rate and buffers them in a small FIFO.
- Releases exactly one sample every DIV clock cycles, with a one-cycle strobe that drives the serializer's sample_ready input.
- Replaces the hard-tied sample_ready with a fixed, jitter-free output sample rate.

Parameters:
- WIDTH, 12, sample width in bits (matches the serializer's sample input).
- DEPTH, 4, FIFO depth in entries; must be a power of two, at least 2.
- DIV, 256, output sample period in clk cycles; at least 2.
- RESET_SAMPLE, 12'h800, value of out_data after reset (DAC midscale).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  sample from the sound core.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a sample this cycle.
- out_data  output  WIDTH  held sample presented to the DAC serializer.
- out_strobe  output  1  one-cycle pulse: out_data has just been (re)loaded.
- fill  output  clog2(DEPTH)+1  current number of FIFO entries.
- underrun  output  1  sticky: a tick occurred while the FIFO was empty.
- overflow  output  1  sticky: in_valid was high while in_ready was low.
- clr_flags  input  1  clears underrun and overflow.

Behaviour:
- Reset is synchronous, active-high, on rst:
  - divider counter = 0; FIFO pointers = 0; fill = 0.
  - out_data = RESET_SAMPLE; out_strobe = 0; underrun = 0; overflow = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Divider:
  - counter runs 0..DIV-1 and wraps to 0.
  - tick = (counter == DIV-1), combinational.
  - First tick is DIV-1 cycles after the reset release edge, then every DIV cycles.
- in_ready = (fill != DEPTH), combinational from registered state.
  - A pop in the same cycle does NOT make room: no push-through when full.
- Push: on an edge where in_valid && in_ready, write in_data at the write pointer; write pointer advances modulo DEPTH.
- Pop: on an edge where tick && fill != 0:
  - out_data <= head entry; read pointer advances modulo DEPTH.
- Tick with fill == 0:
  - out_data holds its value; underrun <= 1.
  - No bypass: a sample pushed on the same edge is not forwarded and becomes visible only at the next tick.
- out_strobe <= tick on every edge, whether or not the FIFO is empty.
  - The strobe is therefore high for exactly one cycle, the cycle after the tick edge, with the new out_data valid in that same cycle.
  - Strobe spacing is exactly DIV cycles.
- fill update on each edge:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
  - Simultaneous push and pop at 0 < fill < DEPTH leaves fill unchanged and keeps ordering correct.
- Output latency: a sample pushed into an empty FIFO appears on out_data after the next tick edge, i.e. 1..DIV cycles later.
- Data ordering is strictly FIFO. Samples are never dropped except when refused at in_ready = 0.
- Overflow: on an edge where in_valid && !in_ready, overflow <= 1; the refused sample is discarded.
- Flags:
  - clr_flags clears both underrun and overflow on that edge.
  - If a set condition occurs on the same edge, set wins and the flag stays 1.
  - Flags persist until cleared or reset.
- Reset mid-operation:
  - All buffered samples are lost; out_data returns to RESET_SAMPLE; the divider restarts from 0.
  - No out_strobe in the cycle following the reset edge, even if a tick was due.
- Width rule: fill is wide enough to hold DEPTH; pointers are clog2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset values (DIV=8): hold rst for 3 cycles -> out_data=12'h800, out_strobe=0, fill=0, in_ready=1, flags 0. First out_strobe appears 8 cycles after the release edge, then every 8 cycles.
- Paced ordering (DIV=8): push 12'h123, 12'h456, 12'h789 on consecutive cycles after reset -> fill=3. On successive strobes out_data reads 12'h123, 12'h456, 12'h789. Then a 4th strobe still occurs with out_data=12'h789 and underrun=1.
- Overflow (DEPTH=4, DIV=256): push 5 samples back-to-back before the first tick -> in_ready=0 after the 4th, 5th sample refused, overflow=1, fill=4. Later pops return only samples 1..4.
- Simultaneous push/pop (DIV=8): with fill=2, assert in_valid on the tick edge -> fill stays 2 and output order is preserved. With fill=4 on a tick edge, in_valid is refused and overflow=1.
- Flag clearing: with underrun=1, assert clr_flags on an edge with no tick -> flag 0. Assert clr_flags on a tick edge with the FIFO empty -> underrun stays 1.
- Reset mid-stream: with fill=3 and out_data=12'h456, assert rst for 1 cycle -> fill=0, out_data=12'h800, no strobe for the next DIV-1 cycles after release.

Source files
------------

// File: rtl/dac_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module   : dac_sample_pacer
// Purpose  : Buffers samples from the sound core in a small FIFO and releases
//            exactly one sample every DIV clock cycles to the SPI DAC
//            serializer, giving a fixed, jitter-free output sample rate.
// Ports    :
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   in_data    - sample from the sound core
//   in_valid   - in_data is valid this cycle
//   in_ready   - FIFO can accept a sample this cycle
//   out_data   - held sample presented to the DAC serializer
//   out_strobe - one-cycle pulse: out_data has just been (re)loaded
//   fill       - current number of FIFO entries
//   underrun   - sticky: a tick occurred while the FIFO was empty
//   overflow   - sticky: in_valid was high while in_ready was low
//   clr_flags  - clears underrun and overflow
// Revision : 1.0 - initial release
// ============================================================================
module dac_sample_pacer #(
  parameter int                WIDTH        = 12,
  parameter int                DEPTH        = 4,
  parameter int                DIV          = 256,
  parameter logic [WIDTH-1:0]  RESET_SAMPLE = 12'h800
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_strobe,
  output logic [$clog2(DEPTH):0]      fill,
  output logic                        underrun,
  output logic                        overflow,
  input  logic                        clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(DIV);

  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [FW-1:0]    r_fill;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_strobe;
  logic             r_underrun;
  logic             r_overflow;

  logic w_tick;
  logic w_push;
  logic w_pop;
  logic w_empty;

  assign w_tick   = (r_cnt == CW'(DIV - 1));
  assign w_empty  = (r_fill == '0);
  // Readiness depends only on registered fill: a pop on the same edge does
  // not free a slot for the incoming sample.
  assign in_ready = (r_fill != FW'(DEPTH));
  assign w_push   = in_valid & in_ready;
  assign w_pop    = w_tick & ~w_empty;

  // Divider: explicit wrap so non-power-of-two DIV values work.
  always_ff @(posedge clk) begin
    if (rst || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Storage array has no reset; contents are only meaningful below fill.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FW'(1);
        2'b01:   r_fill <= r_fill - FW'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Output register: a tick on an empty FIFO re-strobes the held sample,
  // keeping the serializer cadence fixed. A sample pushed on that same edge
  // is not bypassed; it waits for the following tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data   <= RESET_SAMPLE;
      r_out_strobe <= 1'b0;
    end else begin
      r_out_strobe <= w_tick;
      if (w_pop) begin
        r_out_data <= r_mem[r_rd_ptr];
      end
    end
  end

  // Sticky flags: a set condition on the same edge overrides clr_flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_tick && w_empty) begin
        r_underrun <= 1'b1;
      end else if (clr_flags) begin
        r_underrun <= 1'b0;
      end
      if (in_valid && !in_ready) begin
        r_overflow <= 1'b1;
      end else if (clr_flags) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_strobe = r_out_strobe;
  assign fill       = r_fill;
  assign underrun   = r_underrun;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire
